mem_param: RTL



---
 rtl/mem_param.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_param.sv
`default_nettype none
// ============================================================================
// Module   : mem_param
// Brief    : Parametrised request/ack memory with byte enables, configurable
//            read/write latency and an error response.
// Revision : 1.0
// ============================================================================
module mem_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_i,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] data_o,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              wr_q;
  logic              operr_q;
  logic              ack_q, err_q, busy_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              addr_oob;
  logic              req;
  logic              acc_err;
  logic [3:0]        acc_cnt;
  logic              idle;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_data;
  logic [BE_W-1:0]   op_be;
  logic              op_wr;
  logic              op_err;

  if (DEPTH < (1 << ADDR_W)) begin : g_oob
    assign addr_oob = ({1'b0, addr} >= (ADDR_W + 1)'(DEPTH));
  end else begin : g_no_oob
    assign addr_oob = 1'b0;
  end

  // A simultaneous read+write is an error timed like a write.
  assign req     = read | write;
  assign acc_err = (read & write) | addr_oob;
  assign acc_cnt = write ? WR_CNT : RD_CNT;

  // With a latency of one the access completes on the accepting edge itself,
  // so the live request must be used instead of the latched copy.
  assign idle    = (state_q == IDLE);
  assign op_addr = idle ? addr    : addr_q;
  assign op_data = idle ? data_i  : wdata_q;
  assign op_be   = idle ? be      : be_q;
  assign op_wr   = idle ? write   : wr_q;
  assign op_err  = idle ? acc_err : operr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = acc_cnt;
          state_d = (acc_cnt == 4'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      operr_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == DONE);
      err_q   <= (state_d == DONE) & op_err;
      busy_q  <= (state_d != IDLE);
      if (idle && req) begin
        addr_q  <= addr;
        wdata_q <= data_i;
        be_q    <= be;
        wr_q    <= write;
        operr_q <= acc_err;
      end
      if ((state_d == DONE) && !op_err) begin
        if (op_wr) begin
          for (int k = 0; k < BE_W; k++) begin
            if (op_be[k]) begin
              mem_q[op_addr[IDX_W-1:0]][8*k +: 8] <= op_data[8*k +: 8];
            end
          end
        end else begin
          rdata_q <= mem_q[op_addr[IDX_W-1:0]];
        end
      end
    end
  end

  assign data_o = rdata_q;
  assign ack    = ack_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule
`default_nettype wire
